// File: rtl/ir_pkg.sv
// rtl/ir_pkg.sv - shared types and constants for the IR line calibration engine
//
// Purpose: state encoding of the calibration FSM and the default TTD width.
// Ports:   none (package).

package ir_pkg;

  // Default time-to-discharge width in bits
  localparam int TTD_W = 17;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CAL   = 2'd1,
    ST_LATCH = 2'd2,
    ST_RUN   = 2'd3
  } ir_state_e;

endpackage

// File: rtl/ir_line_calib_if.sv
// rtl/ir_line_calib_if.sv - sensor/control bus between TTD source, calibrator and line control
//
// Purpose: groups the TTD sweep input, the calibration command pulses and the
//          classification / status outputs of ir_line_calib.
// Signals:
//   ttd          NCH*W  flattened TTD sweep, channel i at [i*W +: W]
//   sample_valid 1      strobe: ttd holds a complete new sweep
//   cal_start    1      pulse: begin (or restart) calibration
//   cal_end      1      pulse: end calibration, compute thresholds
//   line_bits    NCH    1 = black under channel i
//   line_valid   1      strobe: line_bits updated
//   cal_active   1      calibration in progress
//   cal_err      1      sticky: last calibration failed the span check
//   run_active   1      classifier running
// Modports: master drives the sweep and commands; slave is the calibrator.

interface ir_line_calib_if
  import ir_pkg::*;
#(
  parameter int NCH = 8,
  parameter int W   = TTD_W
) ();

  logic [NCH*W-1:0] ttd;
  logic             sample_valid;
  logic             cal_start;
  logic             cal_end;
  logic [NCH-1:0]   line_bits;
  logic             line_valid;
  logic             cal_active;
  logic             cal_err;
  logic             run_active;

  modport master (
    output ttd, sample_valid, cal_start, cal_end,
    input  line_bits, line_valid, cal_active, cal_err, run_active
  );

  modport slave (
    input  ttd, sample_valid, cal_start, cal_end,
    output line_bits, line_valid, cal_active, cal_err, run_active
  );

endinterface

// File: rtl/ir_chan_cal.sv
// rtl/ir_chan_cal.sv - per-channel min/max tracker, threshold latch and hysteresis classifier
//
// Purpose: owns the calibration extremes, threshold, hysteresis band and
//          black/white decision of a single reflectance channel.
// Ports:
//   WF_CLK    in   1  system clock
//   rst_n     in   1  asynchronous active-low reset
//   clear     in   1  restart calibration: reset extremes, clear decision
//   track     in   1  fold ttd_i into min/max
//   commit    in   1  load threshold/hysteresis from min/max, clear decision
//   classify  in   1  update decision from ttd_i
//   ttd_i     in   W  this channel's time-to-discharge
//   line_bit  out  1  1 = black
//   span_ok   out  1  current (max-min) meets MIN_SPAN

module ir_chan_cal #(
  parameter int W          = 17,
  parameter int HYST_SHIFT = 3,
  parameter int MIN_SPAN   = 64
) (
  input  logic         WF_CLK,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         track,
  input  logic         commit,
  input  logic         classify,
  input  logic [W-1:0] ttd_i,
  output logic         line_bit,
  output logic         span_ok
);

  localparam logic [W-1:0] MIN_SPAN_W = W'(MIN_SPAN);

  logic [W-1:0] min_r;
  logic [W-1:0] max_r;
  logic [W-1:0] thr_r;
  logic [W-1:0] hyst_r;
  logic         bit_r;

  logic [W:0]   sum;
  logic [W-1:0] span;
  logic [W-1:0] thr_calc;
  logic [W-1:0] hyst_calc;
  logic [W:0]   upper;
  logic [W-1:0] lower;
  logic         above;
  logic         below;

  always_comb begin
    sum       = {1'b0, min_r} + {1'b0, max_r};
    thr_calc  = W'(sum >> 1);
    // An empty calibration leaves min above max; treat that as zero span
    span      = (max_r >= min_r) ? (max_r - min_r) : '0;
    hyst_calc = span >> HYST_SHIFT;
    span_ok   = (span >= MIN_SPAN_W);
    // Upper band edge kept in W+1 bits so thr+hyst cannot wrap
    upper     = {1'b0, thr_r} + {1'b0, hyst_r};
    lower     = (thr_r >= hyst_r) ? (thr_r - hyst_r) : '0;
    above     = ({1'b0, ttd_i} > upper);
    below     = (ttd_i < lower);
  end

  always_ff @(posedge WF_CLK or negedge rst_n) begin
    if (!rst_n) begin
      min_r  <= '1;
      max_r  <= '0;
      thr_r  <= '0;
      hyst_r <= '0;
      bit_r  <= 1'b0;
    end else begin
      if (clear) begin
        min_r <= '1;
        max_r <= '0;
        bit_r <= 1'b0;
      end else if (track) begin
        if (ttd_i < min_r) min_r <= ttd_i;
        if (ttd_i > max_r) max_r <= ttd_i;
      end

      if (commit) begin
        thr_r  <= thr_calc;
        hyst_r <= hyst_calc;
        bit_r  <= 1'b0;
      end else if (classify) begin
        if (above)      bit_r <= 1'b1;
        else if (below) bit_r <= 1'b0;
      end
    end
  end

  assign line_bit = bit_r;

endmodule

// File: rtl/ir_line_calib.sv
// rtl/ir_line_calib.sv - per-channel calibration and hysteresis classification of the QTRX array
//
// Purpose: tracks per-channel TTD extremes during calibration, derives a
//          threshold and hysteresis band per channel, then classifies each
//          channel black/white on every run-mode sweep.
// Ports:
//   WF_CLK  in  1      system clock
//   rst_n   in  1      asynchronous active-low reset
//   bus     slave      ir_line_calib_if: ttd, sample_valid, cal_start, cal_end in;
//                      line_bits, line_valid, cal_active, cal_err, run_active out

module ir_line_calib
  import ir_pkg::*;
#(
  parameter int NCH        = 8,
  parameter int W          = TTD_W,
  parameter int HYST_SHIFT = 3,
  parameter int MIN_SPAN   = 64
) (
  input  logic               WF_CLK,
  input  logic               rst_n,
  ir_line_calib_if.slave     bus
);

  ir_state_e      state;
  logic           line_valid_r;
  logic           cal_active_r;
  logic           cal_err_r;
  logic           run_active_r;

  logic           start_acc;
  logic           track;
  logic           classify;
  logic           commit;
  logic           all_ok;
  logic [NCH-1:0] span_ok;
  logic [NCH-1:0] line_bits;

  // LATCH is a single committed cycle; a start pulse landing there is dropped
  assign start_acc = bus.cal_start && (state != ST_LATCH);
  // A start in the same cycle as a sample clears rather than folds
  assign track     = bus.sample_valid && (state == ST_CAL) && !bus.cal_start;
  assign classify  = bus.sample_valid && (state == ST_RUN) && !bus.cal_start;
  assign all_ok    = &span_ok;
  assign commit    = (state == ST_LATCH) && all_ok;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    ir_chan_cal #(
      .W          (W),
      .HYST_SHIFT (HYST_SHIFT),
      .MIN_SPAN   (MIN_SPAN)
    ) u_chan (
      .WF_CLK   (WF_CLK),
      .rst_n    (rst_n),
      .clear    (start_acc),
      .track    (track),
      .commit   (commit),
      .classify (classify),
      .ttd_i    (bus.ttd[g*W +: W]),
      .line_bit (line_bits[g]),
      .span_ok  (span_ok[g])
    );
  end

  always_ff @(posedge WF_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      line_valid_r <= 1'b0;
      cal_active_r <= 1'b0;
      cal_err_r    <= 1'b0;
      run_active_r <= 1'b0;
    end else begin
      line_valid_r <= classify;
      case (state)
        ST_IDLE: begin
          if (bus.cal_start) begin
            state        <= ST_CAL;
            cal_active_r <= 1'b1;
          end
        end
        ST_CAL: begin
          // cal_start has priority over cal_end: stay and restart
          if (!bus.cal_start && bus.cal_end) begin
            state        <= ST_LATCH;
            cal_active_r <= 1'b0;
          end
        end
        ST_LATCH: begin
          if (all_ok) begin
            state        <= ST_RUN;
            run_active_r <= 1'b1;
            cal_err_r    <= 1'b0;
          end else begin
            state        <= ST_IDLE;
            cal_err_r    <= 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.cal_start) begin
            state        <= ST_CAL;
            run_active_r <= 1'b0;
            cal_active_r <= 1'b1;
          end
        end
        default: begin
          state        <= ST_IDLE;
          cal_active_r <= 1'b0;
          run_active_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.line_bits  = line_bits;
  assign bus.line_valid = line_valid_r;
  assign bus.cal_active = cal_active_r;
  assign bus.cal_err    = cal_err_r;
  assign bus.run_active = run_active_r;

endmodule

// File: tb/tb_ir_line_calib.sv
// tb/tb_ir_line_calib.sv - directed self-checking bench for ir_line_calib

module tb_ir_line_calib;

  localparam int NCH = 8;
  localparam int W   = 17;

  logic WF_CLK = 1'b0;
  logic rst_n  = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 WF_CLK = ~WF_CLK;

  ir_line_calib_if #(.NCH(NCH), .W(W)) bus ();

  ir_line_calib #(.NCH(NCH), .W(W), .HYST_SHIFT(3), .MIN_SPAN(64)) dut (
    .WF_CLK (WF_CLK),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  task automatic tick();
    @(posedge WF_CLK);
    #1;
  endtask

  task automatic set_all(input int unsigned v);
    for (int i = 0; i < NCH; i++) bus.ttd[i*W +: W] = W'(v);
  endtask

  task automatic set_ch(input int ch, input int unsigned v);
    bus.ttd[ch*W +: W] = W'(v);
  endtask

  task automatic sample();
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
  endtask

  task automatic start_cal();
    bus.cal_start = 1'b1;
    tick();
    bus.cal_start = 1'b0;
  endtask

  // cal_end cycle followed by the LATCH cycle
  task automatic end_cal();
    bus.cal_end = 1'b1;
    tick();
    bus.cal_end = 1'b0;
    tick();
  endtask

  task automatic calibrate(input int unsigned lo, input int unsigned hi);
    start_cal();
    set_all(lo); sample();
    set_all(hi); sample();
    end_cal();
  endtask

  task automatic test_reset();
    bus.ttd = '0; bus.sample_valid = 0; bus.cal_start = 0; bus.cal_end = 0;
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (bus.line_bits !== 8'h00) begin errors++; $display("FAIL reset_line_bits: got %h expected 00", bus.line_bits); end
    checks++; if (bus.line_valid !== 1'b0) begin errors++; $display("FAIL reset_line_valid: got %b expected 0", bus.line_valid); end
    checks++; if (bus.cal_active !== 1'b0) begin errors++; $display("FAIL reset_cal_active: got %b expected 0", bus.cal_active); end
    checks++; if (bus.cal_err !== 1'b0) begin errors++; $display("FAIL reset_cal_err: got %b expected 0", bus.cal_err); end
    checks++; if (bus.run_active !== 1'b0) begin errors++; $display("FAIL reset_run_active: got %b expected 0", bus.run_active); end
    checks++; if (dut.g_ch[0].u_chan.min_r !== 17'h1FFFF) begin errors++; $display("FAIL reset_min: got %0d expected 131071", dut.g_ch[0].u_chan.min_r); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_calibrate();
    start_cal();
    checks++; if (bus.cal_active !== 1'b1) begin errors++; $display("FAIL cal_enter: cal_active got %b expected 1", bus.cal_active); end
    set_all(1000); sample();
    set_all(3000); sample();
    bus.cal_end = 1'b1;
    tick();
    bus.cal_end = 1'b0;
    checks++; if (bus.cal_active !== 1'b0 || bus.run_active !== 1'b0) begin errors++; $display("FAIL cal_latch: cal/run got %b%b expected 00", bus.cal_active, bus.run_active); end
    tick();
    checks++; if (bus.run_active !== 1'b1) begin errors++; $display("FAIL cal_run: run_active got %b expected 1", bus.run_active); end
    checks++; if (bus.cal_err !== 1'b0) begin errors++; $display("FAIL cal_err_ok: got %b expected 0", bus.cal_err); end
    checks++; if (dut.g_ch[0].u_chan.thr_r !== 17'd2000) begin errors++; $display("FAIL cal_thr0: got %0d expected 2000", dut.g_ch[0].u_chan.thr_r); end
    checks++; if (dut.g_ch[7].u_chan.hyst_r !== 17'd250) begin errors++; $display("FAIL cal_hyst7: got %0d expected 250", dut.g_ch[7].u_chan.hyst_r); end
  endtask

  task automatic test_hysteresis();
    set_all(2000);
    set_ch(0, 2300); sample();
    checks++; if (bus.line_valid !== 1'b1) begin errors++; $display("FAIL hyst_valid_2300: got %b expected 1", bus.line_valid); end
    checks++; if (bus.line_bits !== 8'h01) begin errors++; $display("FAIL hyst_2300: got %h expected 01", bus.line_bits); end
    tick();
    checks++; if (bus.line_valid !== 1'b0) begin errors++; $display("FAIL hyst_valid_pulse: got %b expected 0", bus.line_valid); end
    set_ch(0, 2250); sample();
    checks++; if (bus.line_bits !== 8'h01) begin errors++; $display("FAIL hyst_2250: got %h expected 01", bus.line_bits); end
    set_ch(0, 2000); sample();
    checks++; if (bus.line_bits !== 8'h01) begin errors++; $display("FAIL hyst_2000: got %h expected 01", bus.line_bits); end
    set_ch(0, 1750); sample();
    checks++; if (bus.line_bits !== 8'h01) begin errors++; $display("FAIL hyst_1750: got %h expected 01", bus.line_bits); end
    set_ch(0, 1700); sample();
    checks++; if (bus.line_bits !== 8'h00 || bus.line_valid !== 1'b1) begin errors++; $display("FAIL hyst_1700: bits %h valid %b expected 00 1", bus.line_bits, bus.line_valid); end
  endtask

  task automatic test_reset_mid_run();
    set_all(2000); set_ch(3, 2400); sample();
    checks++; if (bus.line_bits !== 8'h08) begin errors++; $display("FAIL mid_pre: got %h expected 08", bus.line_bits); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.line_bits !== 8'h00 || bus.run_active !== 1'b0 || bus.line_valid !== 1'b0) begin errors++; $display("FAIL mid_async: bits %h run %b valid %b expected 00 0 0", bus.line_bits, bus.run_active, bus.line_valid); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (dut.g_ch[0].u_chan.thr_r !== 17'd0) begin errors++; $display("FAIL mid_thr: got %0d expected 0", dut.g_ch[0].u_chan.thr_r); end
    set_all(5000); sample();
    checks++; if (bus.line_valid !== 1'b0 || bus.cal_active !== 1'b0 || bus.run_active !== 1'b0) begin errors++; $display("FAIL mid_idle: valid %b cal %b run %b expected 0 0 0", bus.line_valid, bus.cal_active, bus.run_active); end
  endtask

  task automatic test_span_fail();
    calibrate(1000, 3000);
    checks++; if (bus.run_active !== 1'b1) begin errors++; $display("FAIL span_pre_run: got %b expected 1", bus.run_active); end
    set_all(2000); set_ch(0, 2300); sample();
    start_cal();
    checks++; if (bus.line_bits !== 8'h00 || bus.run_active !== 1'b0 || bus.cal_active !== 1'b1) begin errors++; $display("FAIL run_to_cal: bits %h run %b cal %b expected 00 0 1", bus.line_bits, bus.run_active, bus.cal_active); end
    set_all(1000); set_ch(5, 1500); sample();
    set_all(3000); set_ch(5, 1500); sample();
    end_cal();
    checks++; if (bus.cal_err !== 1'b1) begin errors++; $display("FAIL span_err: got %b expected 1", bus.cal_err); end
    checks++; if (bus.run_active !== 1'b0 || bus.cal_active !== 1'b0) begin errors++; $display("FAIL span_idle: run %b cal %b expected 0 0", bus.run_active, bus.cal_active); end
    checks++; if (dut.g_ch[5].u_chan.thr_r !== 17'd2000) begin errors++; $display("FAIL span_keep_thr5: got %0d expected 2000", dut.g_ch[5].u_chan.thr_r); end
    checks++; if (dut.g_ch[0].u_chan.hyst_r !== 17'd250) begin errors++; $display("FAIL span_keep_hyst0: got %0d expected 250", dut.g_ch[0].u_chan.hyst_r); end
  endtask

  task automatic test_restart();
    start_cal();
    set_all(100); sample();
    bus.cal_start = 1'b1; bus.cal_end = 1'b1;
    tick();
    bus.cal_start = 1'b0; bus.cal_end = 1'b0;
    checks++; if (bus.cal_active !== 1'b1) begin errors++; $display("FAIL restart_cal: got %b expected 1", bus.cal_active); end
    checks++; if (dut.g_ch[2].u_chan.min_r !== 17'h1FFFF || dut.g_ch[2].u_chan.max_r !== 17'd0) begin errors++; $display("FAIL restart_clear: min %0d max %0d expected 131071 0", dut.g_ch[2].u_chan.min_r, dut.g_ch[2].u_chan.max_r); end
    set_all(1000); sample();
    set_all(3000); sample();
    end_cal();
    checks++; if (bus.run_active !== 1'b1 || bus.cal_err !== 1'b0) begin errors++; $display("FAIL restart_run: run %b err %b expected 1 0", bus.run_active, bus.cal_err); end
    checks++; if (dut.g_ch[2].u_chan.thr_r !== 17'd2000) begin errors++; $display("FAIL restart_thr: got %0d expected 2000", dut.g_ch[2].u_chan.thr_r); end
  endtask

  task automatic test_boundary();
    calibrate(0, 131071);
    checks++; if (dut.g_ch[0].u_chan.thr_r !== 17'd65535) begin errors++; $display("FAIL bound_thr: got %0d expected 65535", dut.g_ch[0].u_chan.thr_r); end
    checks++; if (dut.g_ch[0].u_chan.hyst_r !== 17'd16383) begin errors++; $display("FAIL bound_hyst: got %0d expected 16383", dut.g_ch[0].u_chan.hyst_r); end
    set_all(131071); sample();
    checks++; if (bus.line_bits !== 8'hFF) begin errors++; $display("FAIL bound_max: got %h expected ff", bus.line_bits); end
    set_all(81918); set_ch(1, 0); sample();
    checks++; if (bus.line_bits !== 8'hFD) begin errors++; $display("FAIL bound_edge: got %h expected fd", bus.line_bits); end
  endtask

  task automatic test_no_samples();
    start_cal();
    end_cal();
    checks++; if (bus.cal_err !== 1'b1) begin errors++; $display("FAIL nosamp_err: got %b expected 1", bus.cal_err); end
    checks++; if (bus.cal_active !== 1'b0 || bus.run_active !== 1'b0) begin errors++; $display("FAIL nosamp_idle: cal %b run %b expected 0 0", bus.cal_active, bus.run_active); end
    bus.cal_end = 1'b1; set_all(4000); sample(); bus.cal_end = 1'b0;
    tick();
    checks++; if (bus.cal_active !== 1'b0 || bus.run_active !== 1'b0 || bus.line_valid !== 1'b0) begin errors++; $display("FAIL idle_ignore: cal %b run %b valid %b expected 0 0 0", bus.cal_active, bus.run_active, bus.line_valid); end
  endtask

  initial begin
    test_reset();
    test_calibrate();
    test_hysteresis();
    test_reset_mid_run();
    test_span_fail();
    test_restart();
    test_boundary();
    test_no_samples();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
